rgmii_rx_frame_ctrl: RTL and testbench
======================================

# rgmii_rx_frame_ctrl

Receive frame admission controller between the CRC-checked MAC receive stream and the downstream packet consumer. Buffers each incoming frame in a store-and-forward RAM and commits it only if it is error-free and of legal length; otherwise it rewinds and discards the whole frame. Adds ready/valid backpressure that the non-stallable receive path lacks, and keeps good/dropped frame counters.

## Interface
- DATA_WIDTH, 8, stream data width
- ADDR_WIDTH, 11, log2 buffer depth in beats (2048)
- MIN_LEN, 64, minimum legal frame length in beats (inclusive)
- MAX_LEN, 1518, maximum legal frame length in beats (inclusive); must be ≤ 2**ADDR_WIDTH
- mac_clk  in  1  sole clock
- mac_rst_n  in  1  asynchronous active-low reset
- in_startofpacket / in_endofpacket / in_valid / in_error  in  1 each  receive stream, no backpressure
- in_data  in  DATA_WIDTH  receive data
- out_startofpacket / out_endofpacket / out_valid  out  1 each  committed frame stream
- out_data  out  DATA_WIDTH  committed data
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- frame_ok_count  out  32  frames committed, wraps
- frame_drop_count  out  32  frames discarded, wraps

## Operation
- Buffer entry = {eop, data}; pointers wr_ptr, commit_ptr, rd_ptr are ADDR_WIDTH+1 bits; used = wr_ptr − rd_ptr; full when used == 2**ADDR_WIDTH.
- Write FSM states IDLE, RECV, DISCARD; len counter 12 bits, saturating.
- IDLE: in_valid & in_startofpacket → write beat, len=1, RECV. in_valid without SOP ignored.
- RECV, each in_valid beat: write, len++.
- Drop conditions: in_error on any beat; len > MAX_LEN; beat arrives while full; len < MIN_LEN at EOP.
- Drop detected on non-EOP beat → wr_ptr ← commit_ptr, DISCARD. Drop on EOP beat → wr_ptr ← commit_ptr, IDLE. Each dropped frame increments frame_drop_count once.
- DISCARD: ignore beats until in_endofpacket (→ IDLE) or in_startofpacket (→ new frame, RECV).
- Good EOP: commit_ptr ← wr_ptr+1, frame_ok_count++, IDLE.
- SOP while RECV: current frame dropped (counted), wr_ptr rewound, this beat is first beat of new frame at commit_ptr.
- SOP+EOP same beat: len 1 frame, subject to MIN_LEN check.
- Read side: prefetch from RAM while rd_ptr ≠ commit_ptr into a 2-entry output stage; out_startofpacket on first beat after reset or after an EOP beat; out_endofpacket from stored flag. Never reads uncommitted data.
- Stable-hold: while out_valid & !out_ready, out_* stay constant.

## Timing
- Reset: all outputs 0, counters 0, pointers 0, FSM IDLE, output stage empty, next out beat is SOP.
- RAM read latency 1 cycle; good EOP accepted at cycle T → commit visible T+1 → out_valid earliest T+3 with empty output stage.
- With out_ready held high, output sustains 1 beat/cycle, no bubbles within or between committed frames.
- Counters update the cycle after the deciding beat.
- Commit and read in same cycle legal; full evaluated with rd_ptr of current cycle (read in same cycle does not free space that cycle).
- Reset mid-frame: partial frame and all buffered frames lost, no counter change beyond clear.

## Structure
- Shared package mac_pkg: stream_t packed struct (startofpacket, endofpacket, valid, data, error) and write-FSM state enum.
- Sub-module rgmii_rx_frame_ram: simple dual-port RAM, 2**ADDR_WIDTH × (DATA_WIDTH+1), one write port, registered read port, no reset.

## Test plan
- 64-beat good frame, bytes 0x00..0x3F, out_ready=1 → 64 out beats in order, SOP on 0x00, EOP on 0x3F; ok=1, drop=0.
- 63-beat frame → no out_valid ever; drop=1. 1519-beat frame → drop=1, buffer usage unchanged after EOP.
- 100-beat frame with in_error on EOP beat, then 64-beat good frame → only second frame appears; ok=1, drop=1.
- ADDR_WIDTH=7, MIN_LEN=64, MAX_LEN=100, out_ready=0: two 100-beat frames → first committed, second dropped on overflow; release out_ready → exactly 100 beats out; ok=1, drop=1.
- SOP at beat 40 of frame A, then 70-beat frame B → A dropped, B delivered intact; random out_ready throttling preserves order and SOP/EOP.
- Assert mac_rst_n low at beat 30 of a frame → all outputs/counters 0; next good 64-beat frame delivered with SOP.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types for the MAC receive path: the receive beat bundle and the
// write-side FSM state encoding used by the frame admission controller.
package mac_pkg;

    localparam int unsigned MAC_DW = 8;

    typedef struct packed {
        logic              startofpacket;
        logic              endofpacket;
        logic              valid;
        logic [MAC_DW-1:0] data;
        logic              error;
    } stream_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_e;

endpackage

// File: rtl/rgmii_rx_frame_ram.sv
// Store-and-forward frame buffer: simple dual-port RAM, one write port and a
// registered read port with one cycle of latency. No reset on the array.
module rgmii_rx_frame_ram #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned WIDTH      = 9
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/rgmii_rx_frame_ctrl.sv
// Receive frame admission: buffers each frame, commits only error-free frames
// of legal length, rewinds and discards the rest, and adds ready/valid output.
module rgmii_rx_frame_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MAC_DW,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic                  mac_clk,
    input  logic                  mac_rst_n,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  in_valid,
    input  logic                  in_error,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [31:0]           frame_ok_count,
    output logic [31:0]           frame_drop_count
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);

    stream_t in_s;
    assign in_s = '{startofpacket: in_startofpacket, endofpacket: in_endofpacket,
                    valid: in_valid, data: in_data, error: in_error};

    wr_state_e       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
    logic [11:0]     len_q, len_d, len_nx;
    logic [31:0]     ok_cnt_q, ok_cnt_d, drop_cnt_q;
    logic [1:0]      drop_inc;
    logic [PW-1:0]   base;
    logic            full, drop, accept, ram_we;

    // A SOP always restarts at the last commit point, whatever state we were in.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        ok_cnt_d     = ok_cnt_q;
        drop_inc     = 2'd0;
        base         = in_s.startofpacket ? commit_ptr_q : wr_ptr_q;
        len_nx       = in_s.startofpacket ? 12'd1 : ((len_q == 12'hFFF) ? len_q : len_q + 12'd1);
        full         = (base - rd_ptr_q) == PW'(DEPTH);
        accept       = in_s.valid && (in_s.startofpacket || state_q == ST_RECV);
        drop         = in_s.error || full || (len_nx > MAX_L) ||
                       (in_s.endofpacket && (len_nx < MIN_L));
        ram_we       = accept && !full;
        if (in_s.valid && in_s.startofpacket && state_q == ST_RECV) drop_inc = 2'd1;
        if (accept) begin
            len_d = len_nx;
            if (drop) begin
                wr_ptr_d = commit_ptr_q;
                state_d  = in_s.endofpacket ? ST_IDLE : ST_DISCARD;
                drop_inc = drop_inc + 2'd1;
            end else if (in_s.endofpacket) begin
                wr_ptr_d     = base + PW'(1);
                commit_ptr_d = base + PW'(1);
                ok_cnt_d     = ok_cnt_q + 32'd1;
                state_d      = ST_IDLE;
            end else begin
                wr_ptr_d = base + PW'(1);
                state_d  = ST_RECV;
            end
        end else if (in_s.valid && state_q == ST_DISCARD && in_s.endofpacket) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
            ok_cnt_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
            ok_cnt_q     <= ok_cnt_d;
            drop_cnt_q   <= drop_cnt_q + 32'(drop_inc);
        end
    end

    logic [DATA_WIDTH:0] ram_rdata;

    rgmii_rx_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(DATA_WIDTH + 1)) u_ram (
        .clk     (mac_clk),
        .we_i    (ram_we),
        .waddr_i (base[ADDR_WIDTH-1:0]),
        .wdata_i ({in_s.endofpacket, in_s.data}),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // Two-entry output stage; a read is issued only if its data is guaranteed a slot.
    logic [1:0][DATA_WIDTH:0] ent_q;
    logic                     head_q, pend_q, sop_next_q;
    logic [1:0]               cnt_q, occ;
    logic                     pop, issue;

    assign pop   = out_valid && out_ready;
    assign occ   = cnt_q + {1'b0, pend_q};
    assign issue = (rd_ptr_q != commit_ptr_q) && ((occ < 2'd2) || pop);

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            ent_q      <= '0;
            head_q     <= 1'b0;
            cnt_q      <= 2'd0;
            pend_q     <= 1'b0;
            sop_next_q <= 1'b1;
            rd_ptr_q   <= '0;
        end else begin
            if (pop) begin
                head_q     <= ~head_q;
                sop_next_q <= ent_q[head_q][DATA_WIDTH];
            end
            if (pend_q) ent_q[head_q ^ cnt_q[0]] <= ram_rdata;
            cnt_q  <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
            pend_q <= issue;
            if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign out_valid         = (cnt_q != 2'd0);
    assign out_startofpacket = out_valid && sop_next_q;
    assign out_endofpacket   = out_valid && ent_q[head_q][DATA_WIDTH];
    assign out_data          = out_valid ? ent_q[head_q][DATA_WIDTH-1:0] : '0;
    assign frame_ok_count    = ok_cnt_q;
    assign frame_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_frame_ctrl.sv
// Scoreboard bench: stimulus pushes expected committed beats, independent
// monitors pop and compare on every accepted output beat.
module tb_rgmii_rx_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_sop, in_eop, in_val, in_err;
    logic [7:0]  in_d;
    logic        o_sop, o_eop, o_val, o_rdy;
    logic [7:0]  o_d;
    logic [31:0] ok_c, drop_c;

    logic        in_sop2, in_eop2, in_val2, in_err2;
    logic [7:0]  in_d2;
    logic        o_sop2, o_eop2, o_val2, o_rdy2;
    logic [7:0]  o_d2;
    logic [31:0] ok_c2, drop_c2;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;
    logic [9:0] exp0_q[$];
    logic [9:0] exp1_q[$];

    rgmii_rx_frame_ctrl dut (
        .mac_clk(clk), .mac_rst_n(rst_n),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_valid(in_val),
        .in_error(in_err), .in_data(in_d),
        .out_startofpacket(o_sop), .out_endofpacket(o_eop), .out_valid(o_val),
        .out_data(o_d), .out_ready(o_rdy),
        .frame_ok_count(ok_c), .frame_drop_count(drop_c)
    );

    rgmii_rx_frame_ctrl #(.ADDR_WIDTH(7), .MIN_LEN(64), .MAX_LEN(100)) dut_s (
        .mac_clk(clk), .mac_rst_n(rst_n),
        .in_startofpacket(in_sop2), .in_endofpacket(in_eop2), .in_valid(in_val2),
        .in_error(in_err2), .in_data(in_d2),
        .out_startofpacket(o_sop2), .out_endofpacket(o_eop2), .out_valid(o_val2),
        .out_data(o_d2), .out_ready(o_rdy2),
        .frame_ok_count(ok_c2), .frame_drop_count(drop_c2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Ready driver for the main DUT: 0 = hold low, 1 = hold high, else random.
    initial begin
        o_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       o_rdy = 1'b0;
                1:       o_rdy = 1'b1;
                default: o_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor for the main DUT: beat order/flags plus stable-hold under stall.
    initial begin
        logic [10:0] prev;
        logic [9:0]  e;
        bit          stall;
        stall = 0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall) begin
                    total++;
                    if ({o_val, o_sop, o_eop, o_d} !== prev) begin
                        bad++;
                        $display("FAIL hold0: got=%h want=%h", {o_val, o_sop, o_eop, o_d}, prev);
                    end
                end
                if (o_val && o_rdy) begin
                    total++;
                    if (exp0_q.size() == 0) begin
                        bad++;
                        $display("FAIL beat0: got=%h want=none", {o_sop, o_eop, o_d});
                    end else begin
                        e = exp0_q.pop_front();
                        if ({o_sop, o_eop, o_d} !== e) begin
                            bad++;
                            $display("FAIL beat0: got=%h want=%h", {o_sop, o_eop, o_d}, e);
                        end
                    end
                end
                stall = o_val && !o_rdy;
                prev  = {o_val, o_sop, o_eop, o_d};
            end else begin
                stall = 0;
            end
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && o_val2 && o_rdy2) begin
                total++;
                if (exp1_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat1: got=%h want=none", {o_sop2, o_eop2, o_d2});
                end else begin
                    e = exp1_q.pop_front();
                    if ({o_sop2, o_eop2, o_d2} !== e) begin
                        bad++;
                        $display("FAIL beat1: got=%h want=%h", {o_sop2, o_eop2, o_d2}, e);
                    end
                end
            end
        end
    end

    task automatic beat(input bit sel, input bit s, input bit e, input bit er, input logic [7:0] d);
        if (!sel) begin
            in_sop = s; in_eop = e; in_err = er; in_d = d; in_val = 1'b1;
        end else begin
            in_sop2 = s; in_eop2 = e; in_err2 = er; in_d2 = d; in_val2 = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        in_val = 0; in_sop = 0; in_eop = 0; in_err = 0;
        in_val2 = 0; in_sop2 = 0; in_eop2 = 0; in_err2 = 0;
    endtask

    task automatic frame(input bit sel, input int n, input int err_at, input bit good, input int base);
        bit s, e;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            s = (i == 0);
            e = (i == n - 1);
            d = 8'(base + i);
            if (good) begin
                if (sel) exp1_q.push_back({s, e, d});
                else     exp0_q.push_back({s, e, d});
            end
            beat(sel, s, e, (i == err_at), d);
        end
        quiet();
    endtask

    task automatic wait_drain(input bit sel, input string nm, input int budget);
        int n;
        n = 0;
        while ((sel ? exp1_q.size() : exp0_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(nm, sel ? exp1_q.size() : exp0_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        in_d = '0; in_d2 = '0;
        o_rdy2 = 1'b0;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_val), 0);
        chk("rst_sop", 32'(o_sop), 0);
        chk("rst_eop", 32'(o_eop), 0);
        chk("rst_data", 32'(o_d), 0);
        chk("rst_ok", ok_c, 0);
        chk("rst_drop", drop_c, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 64-beat good frame, first-beat latency after EOP
        frame(0, 64, -1, 1, 0);
        @(negedge clk); chk("lat_t1", 32'(o_val), 0);
        @(negedge clk); chk("lat_t2", 32'(o_val), 0);
        @(negedge clk); chk("lat_t3", 32'(o_val), 1);
        wait_drain(0, "drain_t1", 200);
        chk("t1_ok", ok_c, 1);
        chk("t1_drop", drop_c, 0);

        // runt frames: 63 beats and single SOP+EOP beat
        frame(0, 63, -1, 0, 8'h10);
        frame(0, 1, -1, 0, 8'h77);
        repeat (10) @(posedge clk); #1;
        chk("t2_ok", ok_c, 1);
        chk("t2_drop", drop_c, 2);

        // length boundaries: 1518 accepted, 1519 dropped
        frame(0, 1518, -1, 1, 8'h00);
        wait_drain(0, "drain_t3", 2000);
        frame(0, 1519, -1, 0, 8'h33);
        repeat (5) @(posedge clk); #1;
        chk("t3_ok", ok_c, 2);
        chk("t3_drop", drop_c, 3);

        // error on EOP, followed by a good frame
        frame(0, 100, 99, 0, 8'h90);
        frame(0, 64, -1, 1, 8'h40);
        wait_drain(0, "drain_t4", 200);
        chk("t4_ok", ok_c, 3);
        chk("t4_drop", drop_c, 4);

        // SOP mid-frame restarts; random output throttling
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) beat(0, (i == 0), 1'b0, 1'b0, 8'(8'hA0 + i));
        frame(0, 70, -1, 1, 8'h10);
        wait_drain(0, "drain_t5", 2000);
        chk("t5_ok", ok_c, 4);
        chk("t5_drop", drop_c, 5);
        rdy_mode = 1;
        repeat (3) @(posedge clk); #1;

        // reset in the middle of a frame
        for (int i = 0; i < 30; i++) beat(0, (i == 0), 1'b0, 1'b0, 8'(i));
        quiet();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(o_val), 0);
        chk("mrst_sop", 32'(o_sop), 0);
        chk("mrst_ok", ok_c, 0);
        chk("mrst_drop", drop_c, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(0, 64, -1, 1, 8'h55);
        wait_drain(0, "drain_t6", 200);
        chk("t6_ok", ok_c, 1);
        chk("t6_drop", drop_c, 0);

        // small buffer: second frame overflows while output is stalled
        frame(1, 100, -1, 1, 8'h00);
        frame(1, 100, -1, 0, 8'h64);
        repeat (5) @(posedge clk); #1;
        chk("t7_ok", ok_c2, 1);
        chk("t7_drop", drop_c2, 1);
        chk("t7_valid", 32'(o_val2), 1);
        chk("t7_pending", 32'(exp1_q.size()), 100);
        o_rdy2 = 1'b1;
        wait_drain(1, "drain_t7", 300);
        repeat (20) @(posedge clk); #1;
        chk("t7_idle", 32'(o_val2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
